// File: rtl/exe_muldiv_unit.sv
// Multi-cycle multiply/divide engine for the execute stage. It returns the
// 64-bit result as HI/LO and holds busy high while an operation is in flight.
module exe_muldiv_unit #(
  parameter int         DIV_ITER = 32,
  parameter logic [5:0] HI_ADDR  = 6'd33,
  parameter logic [5:0] LO_ADDR  = 6'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_mul,
  input  logic        is_div,
  input  logic [32:0] src_a,
  input  logic [32:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic [5:0]  out_hi_addr,
  output logic [5:0]  out_lo_addr
);

  localparam int CNT_W = $clog2(DIV_ITER + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic signed [32:0] mul_a_p0;
  logic signed [32:0] mul_b_p0;
  logic signed [63:0] prod_p1;

  logic [31:0] dvd_q;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        sign_q;
  logic        sign_r;
  logic        div_zero;
  logic [31:0] zero_hi;

  logic        accept;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  function automatic logic [31:0] mag32(input logic [32:0] v);
    return v[32] ? 32'(-v) : v[31:0];
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic s);
    return s ? -v : v;
  endfunction

  assign accept      = start && (is_mul || is_div) && !cancel &&
                       (state == IDLE || state == DONE);
  assign busy        = (state == MUL) || (state == DIV) || accept;
  assign out_hi_addr = HI_ADDR;
  assign out_lo_addr = LO_ADDR;

  assign prod_p1 = 64'(mul_a_p0) * 64'(mul_b_p0);

  // One restoring step: the quotient bit shifts into dvd_q as the dividend shifts out.
  always_comb begin
    rem_sh  = {rem, dvd_q[31]};
    ge      = rem_sh >= {1'b0, dvs};
    rem_nxt = ge ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
    quo_nxt = {dvd_q[30:0], ge};
  end

  // Operand capture / iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_a_p0 <= src_a;
      mul_b_p0 <= src_b;
      dvd_q    <= mag32(src_a);
      dvs      <= mag32(src_b);
      rem      <= '0;
      sign_q   <= src_a[32] ^ src_b[32];
      sign_r   <= src_a[32];
      div_zero <= (src_b == 33'd0);
      zero_hi  <= src_a[31:0];
    end else if (state == DIV) begin
      dvd_q <= quo_nxt;
      rem   <= rem_nxt;
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_hi    <= '0;
      out_lo    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) state <= is_mul ? MUL : DIV;
          else        state <= IDLE;
        end
        MUL: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_hi    <= prod_p1[63:32];
            out_lo    <= prod_p1[31:0];
          end
        end
        DIV: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_ITER - 1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_lo    <= div_zero ? 32'hFFFF_FFFF : neg_if(quo_nxt, sign_q);
              out_hi    <= div_zero ? zero_hi : neg_if(rem_nxt, sign_r);
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (accept) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: the driver pushes reference results,
// and a negedge monitor pops and compares them whenever out_valid is seen.
module tb_exe_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_mul = 1'b0;
  logic        is_div = 1'b0;
  logic [32:0] src_a = '0;
  logic [32:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic [5:0]  out_hi_addr;
  logic [5:0]  out_lo_addr;

  exe_muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_mul(is_mul), .is_div(is_div),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .busy(busy),
    .out_valid(out_valid), .out_hi(out_hi), .out_lo(out_lo),
    .out_hi_addr(out_hi_addr), .out_lo_addr(out_lo_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the sign/zero-extended operands.
  function automatic logic [63:0] model(input bit m, input logic [32:0] a, input logic [32:0] b);
    longint sa, sb_, p, q, r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    if (m) begin
      p = sa * sb_;
      return p;
    end
    if (b == 33'd0) return {a[31:0], 32'hFFFF_FFFF};
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {32'd0, cyc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", {32'd0, out_hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, out_lo}, {32'd0, e.lo});
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called during the low clock phase; the request is sampled at the next posedge.
  task automatic issue(input bit m, input bit d, input logic [32:0] a,
                       input logic [32:0] b, input bit push);
    logic [63:0] r;
    exp_t        e;
    start = 1'b1; is_mul = m; is_div = d; src_a = a; src_b = b;
    if (push) begin
      r = model(m, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = cyc + (m ? 2 : 33);
      sb.push_back(e);
      last_hi = r[63:32]; last_lo = r[31:0];
    end
    #1 check("busy_accept", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0; is_mul = 1'b0; is_div = 1'b0;
    src_a = {$urandom, $urandom} & 33'h1_FFFF_FFFF;
    src_b = {$urandom, $urandom} & 33'h1_FFFF_FFFF;
  endtask

  task automatic wait_free();
    int n = 0;
    #1;
    while (busy && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) check("busy_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [32:0] rand_op(input bit sgn);
    logic [31:0] v;
    int          k;
    k = int'($urandom_range(0, 9));
    v = $urandom;
    if (k == 0) v = 32'd0;
    else if (k == 1) v = 32'h8000_0000;
    else if (k == 2) v = 32'hFFFF_FFFF;
    else if (k == 3) v = $urandom_range(1, 20);
    return sgn ? {v[31], v} : {1'b0, v};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_hi", {32'd0, out_hi}, 64'd0);
    check("rst_lo", {32'd0, out_lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("hi_addr", {58'd0, out_hi_addr}, 64'd33);
    check("lo_addr", {58'd0, out_lo_addr}, 64'd32);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // MULT -3 * 7, busy must stay high through C0+1
    issue(1, 0, 33'h1_FFFF_FFFD, 33'h0_0000_0007, 1);
    #1 check("mul_busy_c1", {63'd0, busy}, 64'd1);
    wait_free();
    @(negedge clk);
    issue(1, 0, 33'h0_FFFF_FFFF, 33'h0_0000_0002, 1);
    wait_free();
    @(negedge clk);
    issue(0, 1, 33'h1_FFFF_FFF9, 33'h0_0000_0002, 1);
    wait_free();
    @(negedge clk);
    issue(0, 1, 33'h0_FFFF_FFFF, 33'h0_0000_0010, 1);
    wait_free();
    @(negedge clk);
    issue(0, 1, 33'h0_1234_5678, 33'h0_0000_0000, 1);
    wait_free();
    @(negedge clk);
    issue(0, 1, 33'h1_8000_0000, 33'h1_FFFF_FFFF, 1);
    // wait_free ends in the DONE cycle: launch a MUL with no bubble
    wait_free();
    check("b2b_in_done", {63'd0, out_valid}, 64'd1);
    issue(1, 1, 33'h0_0001_0000, 33'h0_0001_0000, 1);
    wait_free();

    // Stray start while dividing must be ignored
    @(negedge clk);
    issue(0, 1, 33'h0_0000_0064, 33'h0_0000_0007, 1);
    repeat (5) @(negedge clk);
    start = 1'b1; is_mul = 1'b1; src_a = 33'd5; src_b = 33'd5;
    #1 check("busy_in_div", {63'd0, busy}, 64'd1);
    @(negedge clk);
    start = 1'b0; is_mul = 1'b0;
    wait_free();

    // Cancel around iteration 10
    @(negedge clk);
    issue(0, 1, 33'h0_0000_1000, 33'h0_0000_0003, 0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    #1;
    check("cancel_hi", {32'd0, out_hi}, {32'd0, last_hi});
    check("cancel_lo", {32'd0, out_lo}, {32'd0, last_lo});

    // Reset in the middle of a multiply
    issue(1, 0, 33'h0_0000_0003, 33'h0_0000_0005, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_hi", {32'd0, out_hi}, 64'd0);
    check("midrst_lo", {32'd0, out_lo}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    last_hi = '0; last_lo = '0;
    @(negedge clk);

    // Randomized traffic, sometimes issued in the DONE cycle
    for (int i = 0; i < 60; i++) begin
      bit m, d, s;
      m = 1'($urandom_range(0, 1));
      d = m ? 1'($urandom_range(0, 1)) : 1'b1;
      s = 1'($urandom_range(0, 1));
      issue(m, d, rand_op(s), rand_op(s), 1);
      wait_free();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Execute-stage multi-cycle multiply/divide engine that consumes the decode stage's double-width request (double_en, mul, div, 33-bit extended rs/rt).
- Returns the 64-bit result as HI/LO for writeback to regfile addresses 6'd33 (HI) and 6'd32 (LO).
- Signedness is carried entirely by the 33-bit operand extension: signed ops arrive sign-extended, unsigned ops zero-extended.
- Asserts busy to stall the pipeline while an operation is in flight.

Parameters:
DIV_ITER, 32, number of restoring-division iterations (one quotient bit per cycle)
HI_ADDR, 6'd33, regfile address driven with HI result
LO_ADDR, 6'd32, regfile address driven with LO result

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  request from decode (double_en), sampled on rising edge
is_mul  input  1  request is MULT/MULTU
is_div  input  1  request is DIV/DIVU
src_a  input  33  extended rs (multiplicand / dividend)
src_b  input  33  extended rt (multiplier / divisor)
cancel  input  1  flush of in-flight op (exception/kill)
busy  output  1  stall request to pipeline
out_valid  output  1  one-cycle pulse: hi/lo valid, write both to regfile
out_hi  output  32  HI result
out_lo  output  32  LO result
out_hi_addr  output  6  constant HI_ADDR
out_lo_addr  output  6  constant LO_ADDR

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- States: IDLE, MUL, DIV, DONE.
- Reset (also mid-operation): state=IDLE, iteration counter=0, out_valid=0, out_hi=0, out_lo=0. Any in-flight op is discarded.
- Accept rule:
  - start is accepted only in IDLE or DONE.
  - is_mul wins if both is_mul and is_div are set.
  - start with neither set is ignored.
  - start in MUL/DIV is ignored; the pipeline must already be stalled.
- busy (combinational) = (state==MUL or DIV) OR (accepted start this cycle). busy=0 in DONE.
- Multiply path:
  - IDLE -(start&is_mul)-> MUL -> DONE.
  - Computes the full signed 33x33 product; out_hi=prod[63:32], out_lo=prod[31:0].
  - out_valid is high 2 cycles after the start cycle (start cycle C0, out_valid in C0+2).
- Divide path:
  - On accept, latch |a|, |b| (32-bit magnitudes), sign_q = a[32]^b[32], sign_r = a[32]; counter=0.
  - DIV performs one restoring iteration per cycle.
  - After DIV_ITER iterations: DONE. Quotient is negated if sign_q, remainder negated if sign_r.
  - out_lo=quotient, out_hi=remainder. out_valid in C0+33.
- Divide by zero (src_b==0): same latency; out_lo=32'hFFFFFFFF, out_hi=src_a[31:0] as latched at accept.
- Signed overflow 0x80000000 / -1: out_lo=32'h80000000, out_hi=0. Not trapped.
- DONE:
  - out_valid=1 for exactly this cycle.
  - Next state: IDLE, or MUL/DIV if a new start is accepted this cycle (back-to-back, no bubble).
- out_hi/out_lo hold the last result until the next DONE. They change only on entering DONE.
- cancel:
  - In MUL/DIV: next state IDLE, no out_valid, hi/lo unchanged; busy drops the following cycle.
  - cancel with start in the same cycle: start is ignored.
  - cancel in IDLE/DONE: no effect on a DONE pulse already presented.
- Arithmetic is internal 33-bit / 66-bit as needed; only the low 64 product bits are used.

Test Plan:
- MULT: src_a=33'h1FFFFFFFD (-3), src_b=33'h000000007 -> out_valid in C0+2, out_hi=FFFFFFFF, out_lo=FFFFFFEB, busy high in C0,C0+1.
- MULTU: src_a=33'h0FFFFFFFF, src_b=33'h000000002 -> out_hi=00000001, out_lo=FFFFFFFE.
- DIV signed: -7 (33'h1FFFFFFF9) / 2 -> out_valid only in C0+33, out_lo=FFFFFFFD, out_hi=FFFFFFFF. DIVU 33'h0FFFFFFFF/16 -> out_lo=0FFFFFFF, out_hi=0000000F.
- Boundaries: divisor 0 with a=0x12345678 -> out_lo=FFFFFFFF, out_hi=12345678. Signed 33'h180000000 / 33'h1FFFFFFFF -> out_lo=80000000, out_hi=0.
- Back-to-back: start MUL asserted during DONE of a DIV -> new out_valid exactly 2 cycles later. Start pulsed while in DIV -> ignored, result unaffected.
- cancel at DIV iteration 10 -> busy=0 next cycle, no out_valid, hi/lo keep previous values. reset asserted mid-MUL -> IDLE, all outputs 0 next cycle.
